// File: rtl/claim_parser.sv
// claim_parser: streaming parser for a claim list of lines of the form
// "#<id> @ <x>,<y>: <w>x<h>\n". Each well-formed line becomes one packed
// {x, y, w, h} record written to a claim store.
//
// Parameters:
//   MAX_CLAIMS  claim-store depth; writing one more record is a fatal error
//   FW          width of each numeric field (x, y, w, h), FW >= 4
//   AW          claim-store address width
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_char    one ASCII character per accepted cycle
//   in_last             marks in_char as the final character of the list
//   in_ready            parser can take a character (state-only, no in_valid path)
//   wr_en/wr_addr/wr_data  registered one-cycle claim-store write
//   claim_count         records written so far
//   done                sticky, list complete
//   error               sticky fatal error (parse without resync, or overflow)
//   err_count           malformed lines skipped (resync builds, else 0)
//
// Build option: define CLAIM_PARSER_RESYNC_EN to skip malformed lines
// (counted in err_count) instead of stopping in ERROR. Store overflow is
// fatal in both builds.
module claim_parser #(
  parameter int MAX_CLAIMS = 1236,
  parameter int FW         = 10,
  parameter int AW         = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_char,
  input  logic            in_last,
  output logic            in_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [4*FW-1:0] wr_data,
  output logic [AW-1:0]   claim_count,
  output logic            done,
  output logic            error,
  output logic [7:0]      err_count
);

  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_COMMA = 8'h2C;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_X     = 8'h78;
  localparam logic [7:0] CH_NL    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  // SKIP is only reachable in resync builds (discarding a malformed line).
  typedef enum logic [3:0] {
    IDLE, ID, SEP_AT, X, Y, SEP_COLON, W, H, DONE, ERROR, SKIP
  } state_t;

  state_t        state, state_n;
  logic [FW-1:0] acc, acc_n;       // field being accumulated
  logic          nd, nd_n;         // current field has at least one digit
  logic [FW-1:0] x_q, y_q, w_q, x_n, y_n, w_n;
  logic [FW-1:0] h_val;
  logic          wr_go, emit, perr;

  logic          take, is_digit, is_nl, acc_ovf;
  logic [3:0]    dval;
  logic [FW+3:0] acc_ext, acc_mul;

  assign in_ready = (state != DONE) && (state != ERROR);
  assign done     = (state == DONE);
  assign error    = (state == ERROR);

  assign take     = in_valid && in_ready;
  assign is_digit = (in_char >= 8'h30) && (in_char <= 8'h39);
  assign is_nl    = (in_char == CH_NL);
  assign dval     = in_char[3:0];
  // acc*10 + digit at FW+4 bits; anything in the top nibble is out of range.
  assign acc_ext  = {4'd0, acc};
  assign acc_mul  = (acc_ext << 3) + (acc_ext << 1) + {{FW{1'b0}}, dval};
  assign acc_ovf  = |acc_mul[FW+3:FW];

`ifdef CLAIM_PARSER_RESYNC_EN
  logic       err_inc;
  logic [7:0] err_cnt_q;
`endif

  always_comb begin
    state_n = state;
    acc_n   = acc;
    nd_n    = nd;
    x_n     = x_q;
    y_n     = y_q;
    w_n     = w_q;
    h_val   = acc;
    emit    = 1'b0;
    perr    = 1'b0;
    wr_go   = 1'b0;
`ifdef CLAIM_PARSER_RESYNC_EN
    err_inc = 1'b0;
`endif
    if (take) begin
      if (in_char == CH_CR) begin
        // CR never changes parse state; it only matters if it ends the list.
        if (in_last) begin
          if (state == IDLE || state == SKIP) state_n = DONE;
          else if (state == H && nd)          emit    = 1'b1;
          else                                perr    = 1'b1;
        end
      end else begin
        unique case (state)
          IDLE:
            if (in_char == CH_HASH) begin
              state_n = ID;
              nd_n    = 1'b0;
            end else if (!is_nl) perr = 1'b1;
          ID:
            if (is_digit) nd_n = 1'b1;
            else if (in_char == CH_SP && nd) state_n = SEP_AT;
            else perr = 1'b1;
          SEP_AT:
            if (is_digit) begin
              acc_n   = {{(FW-4){1'b0}}, dval};
              nd_n    = 1'b1;
              state_n = X;
            end else if (in_char != CH_SP && in_char != CH_AT) perr = 1'b1;
          X, Y, W:
            if (is_digit) begin
              if (acc_ovf) perr = 1'b1;
              else begin
                acc_n = acc_mul[FW-1:0];
                nd_n  = 1'b1;
              end
            end else if (state == X && in_char == CH_COMMA) begin
              x_n = acc; acc_n = '0; nd_n = 1'b0; state_n = Y;
            end else if (state == Y && in_char == CH_COLON && nd) begin
              y_n = acc; acc_n = '0; nd_n = 1'b0; state_n = SEP_COLON;
            end else if (state == W && in_char == CH_X) begin
              w_n = acc; acc_n = '0; nd_n = 1'b0; state_n = H;
            end else perr = 1'b1;
          SEP_COLON:
            if (is_digit) begin
              acc_n   = {{(FW-4){1'b0}}, dval};
              nd_n    = 1'b1;
              state_n = W;
            end else if (in_char != CH_SP) perr = 1'b1;
          H:
            if (is_digit) begin
              if (acc_ovf) perr = 1'b1;
              else begin
                acc_n = acc_mul[FW-1:0];
                nd_n  = 1'b1;
                // A list ending on a digit closes the record with that digit.
                if (in_last) begin
                  emit  = 1'b1;
                  h_val = acc_mul[FW-1:0];
                end
              end
            end else if (is_nl && nd) emit = 1'b1;
            else perr = 1'b1;
          SKIP:
            if (is_nl) state_n = IDLE;
          default: ;
        endcase
        // End of list anywhere other than a line boundary is malformed.
        if (in_last && !perr && !emit) begin
          if ((state == IDLE && is_nl) || state == SKIP) state_n = DONE;
          else perr = 1'b1;
        end
      end

      if (emit) begin
        if (claim_count == AW'(MAX_CLAIMS)) state_n = ERROR;
        else begin
          wr_go   = 1'b1;
          state_n = in_last ? DONE : IDLE;
          acc_n   = '0;
          nd_n    = 1'b0;
        end
      end

      if (perr) begin
`ifdef CLAIM_PARSER_RESYNC_EN
        // Drop the line; a newline that triggered the error already ends it.
        err_inc = 1'b1;
        acc_n   = '0;
        nd_n    = 1'b0;
        state_n = in_last ? DONE : (is_nl ? IDLE : SKIP);
`else
        state_n = ERROR;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      nd          <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      claim_count <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      nd    <= nd_n;
      x_q   <= x_n;
      y_q   <= y_n;
      w_q   <= w_n;
      wr_en <= wr_go;
      if (wr_go) begin
        wr_addr     <= claim_count;
        wr_data     <= {x_q, y_q, w_q, h_val};
        claim_count <= claim_count + AW'(1);
      end
    end
  end

`ifdef CLAIM_PARSER_RESYNC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               err_cnt_q <= '0;
    else if (err_inc && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_claim_parser.sv
// Scoreboard bench for claim_parser. A line-level reference model turns each
// stimulus string into expected records (queued) and final status; a monitor
// pops and compares on every wr_en. A second instance with MAX_CLAIMS=2 sees
// the same character stream and is checked for store overflow.
module tb_claim_parser;
  localparam int FW   = 10;
  localparam int AW   = 11;
  localparam int MAXC = 1236;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_last;
  logic [7:0]      in_char;
  logic            in_ready, wr_en, done, error;
  logic [AW-1:0]   wr_addr, claim_count;
  logic [4*FW-1:0] wr_data;
  logic [7:0]      err_count;
  logic            in_ready2, wr_en2, done2, error2;
  logic [AW-1:0]   wr_addr2, claim_count2;
  logic [4*FW-1:0] wr_data2;
  logic [7:0]      err_count2;

  claim_parser #(.MAX_CLAIMS(MAXC), .FW(FW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
    .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .claim_count(claim_count), .done(done), .error(error),
    .err_count(err_count));

  claim_parser #(.MAX_CLAIMS(2), .FW(FW), .AW(AW)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char),
    .in_last(in_last), .in_ready(in_ready2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .claim_count(claim_count2), .done(done2), .error(error2),
    .err_count(err_count2));

  always #5 clk = ~clk;

  typedef struct {
    int              addr;
    logic [4*FW-1:0] data;
    bit              last;
  } rec_t;

  rec_t sb[$];
  int   tests = 0, fails = 0, mon_tests = 0, mon_fails = 0;
  int   wr2_cnt;
  int   exp_n, exp_ec;
  bit   exp_err, exp_done, stop;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    rec_t e;
    if (wr_en) begin
      mon_tests++;
      if (sb.size() == 0) begin
        mon_fails++;
        $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== AW'(e.addr) || wr_data !== e.data || done !== e.last) begin
          mon_fails++;
          $display("FAIL record got addr=%0d data=%h done=%b exp addr=%0d data=%h done=%b",
                   wr_addr, wr_data, done, e.addr, e.data, e.last);
        end
      end
    end
  end

  always @(negedge clk or posedge rst)
    if (rst) wr2_cnt <= 0;
    else if (wr_en2) wr2_cnt <= wr2_cnt + 1;

  initial begin
    #3_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit expect_c(input byte q[$], inout int p, input byte c);
    if (p < q.size() && q[p] == c) begin
      p++;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit get_num(input byte q[$], inout int p, output int v, input bit ranged);
    int n = 0;
    v = 0;
    while (p < q.size() && q[p] >= "0" && q[p] <= "9") begin
      if (ranged) begin
        v = v * 10 + int'(q[p] - "0");
        if (v > (1 << FW) - 1) return 1'b0;
      end
      p++;
      n++;
    end
    return n > 0;
  endfunction

  function automatic bit parse_line(input byte q[$], output logic [4*FW-1:0] d);
    int p = 0, id, vx, vy, vw, vh;
    d = '0;
    if (!expect_c(q, p, "#") || !get_num(q, p, id, 1'b0) || !expect_c(q, p, " ")) return 1'b0;
    while (p < q.size() && (q[p] == " " || q[p] == "@")) p++;
    if (!get_num(q, p, vx, 1'b1) || !expect_c(q, p, ",")) return 1'b0;
    if (!get_num(q, p, vy, 1'b1) || !expect_c(q, p, ":")) return 1'b0;
    while (p < q.size() && q[p] == " ") p++;
    if (!get_num(q, p, vw, 1'b1) || !expect_c(q, p, "x")) return 1'b0;
    if (!get_num(q, p, vh, 1'b1)) return 1'b0;
    d = {FW'(vx), FW'(vy), FW'(vw), FW'(vh)};
    return p == q.size();
  endfunction

  task automatic do_line(input byte q[$], input bit last);
    logic [4*FW-1:0] d;
    rec_t r;
    if (q.size() == 0) return;
    if (parse_line(q, d)) begin
      if (exp_n == MAXC) begin
        exp_err = 1'b1;
        stop    = 1'b1;
      end else begin
        r.addr = exp_n; r.data = d; r.last = last;
        sb.push_back(r);
        exp_n++;
      end
    end else begin
`ifdef CLAIM_PARSER_RESYNC_EN
      if (exp_ec < 255) exp_ec++;
`else
      exp_err = 1'b1;
      stop    = 1'b1;
`endif
    end
  endtask

  task automatic run_model(input string s);
    byte q[$];
    byte c;
    exp_n = 0; exp_ec = 0; exp_err = 0; exp_done = 0; stop = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c == "\r") continue;
      if (c == "\n") begin
        do_line(q, i == s.len() - 1);
        q.delete();
        if (stop) break;
      end else q.push_back(c);
    end
    if (!stop) begin
      if (q.size() > 0) do_line(q, 1'b1);
      if (!stop) exp_done = 1'b1;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send(input string s, input bit use_last, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (!in_ready) break;
      in_valid = 1'b1;
      in_char  = s[i];
      in_last  = use_last && (i == s.len() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic finish_checks(input string tag);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_sb_left"}, sb.size(), 0);
    sb.delete();
    chk({tag, "_count"}, int'(claim_count), exp_n);
    chk({tag, "_done"}, int'(done), int'(exp_done));
    chk({tag, "_error"}, int'(error), int'(exp_err));
    chk({tag, "_err_count"}, int'(err_count), exp_ec);
  endtask

  task automatic run_stream(input string tag, input string s, input bit gaps);
    do_reset();
    run_model(s);
    send(s, 1'b1, gaps);
    finish_checks(tag);
  endtask

  function automatic string gen_line();
    string sa[3], sc[3], pool, s;
    int v[4], idx;
    sa[0] = " @ "; sa[1] = " @"; sa[2] = "  @ ";
    sc[0] = ": ";  sc[1] = ":";  sc[2] = ":  ";
    pool = "#@ ,:xq5";
    for (int k = 0; k < 4; k++)
      v[k] = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1024, 1100))
                                          : int'($urandom_range(0, 1023));
    s = $sformatf("#%0d%s%0d,%0d%s%0dx%0d", $urandom_range(0, 999),
                  sa[$urandom_range(0, 2)], v[0], v[1], sc[$urandom_range(0, 2)], v[2], v[3]);
    if ($urandom_range(0, 14) == 0) begin
      idx = $urandom_range(0, s.len() - 1);
      s.putc(idx, pool.getc($urandom_range(0, pool.len() - 1)));
    end
    return s;
  endfunction

  initial begin
    string s, eol;
    int nl;
    rst = 1'b1; in_valid = 1'b0; in_char = '0; in_last = 1'b0;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_claim_count", int'(claim_count), 0);
    chk("rst_err_count", int'(err_count), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_wr_data", (wr_data == '0) ? 1 : 0, 1);

    run_stream("single", "#1 @ 1,3: 4x4\n", 1'b0);
    run_stream("three_nolf", "#1 @ 1,1: 1x1\n#2 @ 2,2: 3x3\n#3 @ 5,5: 2x2", 1'b0);

    run_stream("field_ovf", "#1 @ 1024,1: 1x1\n#2 @ 6,7: 8x9\n", 1'b0);
`ifndef CLAIM_PARSER_RESYNC_EN
    chk("field_ovf_in_ready", int'(in_ready), 0);
`endif

    run_stream("store_full", "#1 @ 1,1: 1x1\n#2 @ 2,2: 2x2\n#3 @ 3,3: 3x3\n", 1'b0);
    chk("full_writes", wr2_cnt, 2);
    chk("full_error", int'(error2), 1);
    chk("full_count", int'(claim_count2), 2);

    // Abort mid-line with a record already in the store.
    do_reset();
    run_model("#2 @ 3,4: 5x6\n");
    sb[0].last = 1'b0;
    send("#2 @ 3,4: 5x6\n#7 @ 12,", 1'b0, 1'b0);
    chk("pre_rst_count", int'(claim_count), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_count", int'(claim_count), 0);
    chk("mid_rst_wr_data", (wr_data == '0) ? 1 : 0, 1);
    chk("mid_rst_wr_en", int'(wr_en), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_sb_left", sb.size(), 0);
    sb.delete();
    run_model("#1 @ 0,0: 1x1\n");
    send("#1 @ 0,0: 1x1\n", 1'b1, 1'b0);
    finish_checks("after_rst");

    for (int t = 0; t < 30; t++) begin
      s   = "";
      eol = ($urandom_range(0, 1) == 1) ? "\r\n" : "\n";
      if ($urandom_range(0, 4) == 0) s = {s, eol};
      nl = $urandom_range(1, 5);
      for (int k = 0; k < nl; k++) begin
        s = {s, gen_line()};
        if (k < nl - 1 || $urandom_range(0, 1) == 1) s = {s, eol};
      end
      run_stream($sformatf("rand%0d", t), s, 1'b1);
    end

    tests += mon_tests;
    fails += mon_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/claim_parser.md
CLAIM_PARSER -- requirements
Module: claim_parser

Interface
REQ-001 The block SHALL have parameter MAX_CLAIMS, default 1236, meaning the claim-store depth; records beyond it are an overflow error.
REQ-002 The block SHALL have parameter FW, default 10, meaning the bit width of each numeric field (x, y, w, h).
REQ-003 The block SHALL have parameter AW, default 11, meaning the claim-store address width.
REQ-004 clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 in_valid  input  1  in_char is presented this cycle.
REQ-007 in_char  input  8  one ASCII character of the claim list.
REQ-008 in_last  input  1  marks in_char as the final character of the list.
REQ-009 in_ready  output  1  the parser accepts in_char this cycle.
REQ-010 wr_en  output  1  one-cycle claim-store write strobe.
REQ-011 wr_addr  output  AW  claim index, starting at 0.
REQ-012 wr_data  output  4*FW  packed {x, y, w, h}, with x in the most significant field.
REQ-013 claim_count  output  AW  number of records written so far.
REQ-014 done  output  1  sticky; the list is complete and the downstream overlap stage may start.
REQ-015 error  output  1  sticky parse, overflow or claim-store-full error.
REQ-016 err_count  output  8  number of malformed lines skipped (RESYNC builds only; reads 0 otherwise).

Function
REQ-017 The parser SHALL accept lines of the form "#<id> @ <x>,<y>: <w>x<h>" followed by '\n'; '\r' SHALL be ignored in every state.
REQ-018 The state machine SHALL have the states IDLE, ID, SEP_AT, X, Y, SEP_COLON, W, H, DONE and ERROR.
REQ-019 State transitions SHALL be:
- IDLE: '#' -> ID; '\n' -> stay (blank line).
- ID: digit -> stay; ' ' -> SEP_AT.
- SEP_AT: ' ' or '@' -> stay; first digit -> X.
- X: ',' -> Y.
- Y: ':' -> SEP_COLON.
- SEP_COLON: ' ' -> stay; first digit -> W.
- W: 'x' -> H.
- H: '\n' -> IDLE and emit the record.
- Any other character -> ERROR.
REQ-020 The id value SHALL be parsed for syntax only and discarded.
REQ-021 Field accumulation SHALL be acc <= acc*10 + (in_char - 0x30), computed at FW+4 bits; a result above 2^FW-1 SHALL be a parse error.
REQ-022 A field with zero digits SHALL be a parse error.
REQ-023 A character SHALL be consumed on the clk edge where in_valid && in_ready.
REQ-024 in_ready SHALL be 1 in every state except DONE and ERROR.
REQ-025 in_ready SHALL NOT depend combinationally on in_valid.
REQ-026 A record SHALL be emitted one cycle after its terminating character is accepted: wr_en high for exactly one cycle, wr_addr equal to the prior claim_count, wr_data holding the packed fields.
REQ-027 claim_count SHALL increment in the same cycle that wr_en is high.
REQ-028 When in_last is accepted with a digit in state H, the record SHALL be emitted as if '\n' followed it.
REQ-029 When in_last is accepted with '\n' in H or in IDLE, the parser SHALL go to DONE.
REQ-030 When in_last is accepted in any other state, it SHALL be a parse error.
REQ-031 done SHALL rise in the same cycle as the final wr_en, or one cycle after in_last is accepted when no record is pending.
REQ-032 An attempt to emit a record when claim_count == MAX_CLAIMS SHALL suppress wr_en, assert error and enter ERROR, regardless of configuration.
REQ-033 in_valid low in any state SHALL hold all state.
REQ-034 wr_en, wr_addr and wr_data SHALL be registered outputs.

Reset
REQ-035 While rst is high, the state SHALL be IDLE and all accumulators 0.
REQ-036 While rst is high, wr_en, done, error, claim_count, err_count, wr_addr and wr_data SHALL all be 0, and in_ready SHALL be 1.
REQ-037 A rst asserted mid-line or mid-write SHALL abort immediately; a partial record SHALL never be written.
REQ-038 After rst is released, parsing SHALL restart from IDLE with claim_count at 0.

Configuration
REQ-039 With macro CLAIM_PARSER_RESYNC_EN defined, a parse error SHALL discard the current line, increment err_count (saturating at 255), skip characters up to and including '\n', then return to IDLE with error left low.
REQ-040 With CLAIM_PARSER_RESYNC_EN defined, an in_last accepted while skipping a line SHALL go to DONE.
REQ-041 With CLAIM_PARSER_RESYNC_EN defined, overflow SHALL remain fatal as stated in REQ-032.
REQ-042 Without CLAIM_PARSER_RESYNC_EN, any parse error SHALL enter ERROR and assert error, which stays sticky with in_ready low until rst.
REQ-043 Without CLAIM_PARSER_RESYNC_EN, err_count SHALL be tied to 0.

Verification
REQ-044 Stream "#1 @ 1,3: 4x4\n" with in_last on '\n' -> one wr_en, wr_addr 0, wr_data {1,3,4,4}, claim_count 1, done high, error 0.
REQ-045 Three lines with the last lacking '\n' ("#3 @ 5,5: 2x2" with in_last on the final '2') -> wr_addr 0, 1, 2 in order, the third record {5,5,2,2}, done in the same cycle as the third wr_en.
REQ-046 Field "1024" with FW=10 -> no wr_en; error=1 and in_ready=0 without the macro; with the macro, err_count=1 and the next valid line written at wr_addr 0.
REQ-047 MAX_CLAIMS=2 and three valid lines -> exactly two writes, error=1 after the third '\n', claim_count stays 2.
REQ-048 rst pulsed after "#7 @ 12," -> outputs zeroed asynchronously; a following "#1 @ 0,0: 1x1\n" writes {0,0,1,1} at wr_addr 0.
REQ-049 in_valid toggled randomly with "\r\n" line endings -> records identical to the gapless run with '\n' endings.
